// File: rtl/secuenciador_alu.sv
// ---------------------------------------------------------------------------
// secuenciador_alu
//   Scheduler that lets two requesters share one 4-bit ALU. It accepts one
//   instruction/operand pair at a time and chooses between the requesters
//   round-robin. The accepted operands stay on the ALU inputs for ALU_LAT
//   cycles, the ALU result is then captured, and it is returned on a
//   valid/ready response tagged with the id of the requester that issued it.
//   Opcode 3'h6 is not supported by the ALU. It is answered at once with
//   rsp_err set, and no ALU cycles are spent on it.
//
// Parameters
//   ALU_LAT     cycles from operand presentation to a valid alu_result (1..15)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/_ready       request handshake, one per requester
//   req{0,1}_instr/_a/_b        instruction ([7:5] = opcode) and operands
//   alu_instr/alu_a/alu_b       registered operands driven to the ALU
//   alu_result                  ALU output, sampled after ALU_LAT cycles
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_id/rsp_err     captured result, requester id, error flag
//   busy                        scheduler is not idle
// ---------------------------------------------------------------------------
module secuenciador_alu #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_instr,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_instr,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [7:0] alu_instr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);
  localparam logic [2:0] OP_UNSUP = 3'h6;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] alu_instr_q, alu_instr_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;
  logic       rsp_err_q, rsp_err_d;

  // Arbitration. When both requesters are valid, the one that was not granted
  // last time wins. When only one is valid, that one wins.
  logic       any_valid;
  logic       grant_id;
  logic       accept;
  logic [7:0] sel_instr;
  logic [3:0] sel_a;
  logic [3:0] sel_b;

  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    accept    = (state_q == IDLE) & any_valid;
    sel_instr = grant_id ? req1_instr : req0_instr;
    sel_a     = grant_id ? req1_a     : req0_a;
    sel_b     = grant_id ? req1_b     : req0_b;
  end

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept &  grant_id;

  // NOTE: every _d signal defaults to its _q value first, so no branch of the
  // case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_instr_d  = alu_instr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_instr_d  = sel_instr;
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          if (sel_instr[7:5] == OP_UNSUP) begin
            // The ALU cannot execute this opcode, so reply with an error at once.
            rsp_err_d  = 1'b1;
            rsp_data_d = 4'h0;
            state_d    = RESP;
          end else begin
            rsp_err_d = 1'b0;
            cnt_d     = LAT_LOAD;
            state_d   = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // A count of 1 marks the last cycle of the ALU latency window, where
        // alu_result becomes valid.
        if (cnt_q == 4'd1) begin
          rsp_data_d = alu_result;
          state_d    = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // reaches a known value on reset, so outputs are defined from the first
  // cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'h0;
      last_grant_q <= 1'b1;  // requester 0 wins the first arbitration
      alu_instr_q  <= 8'h00;
      alu_a_q      <= 4'h0;
      alu_b_q      <= 4'h0;
      rsp_data_q   <= 4'h0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_instr_q  <= alu_instr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_instr = alu_instr_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_secuenciador_alu.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_alu
//   Directed bench for secuenciador_alu. It builds three instances with
//   ALU_LAT = 2, 1 and 15. Each instance is paired with a behavioural ALU that
//   returns a wrong value until its operands have been stable for ALU_LAT
//   cycles. Each instance also has a scoreboard: the expected response is
//   pushed on every request handshake and popped on every response handshake.
//   Timing and arbitration points are checked inline. Inputs are driven 1 time
//   unit after the rising edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_secuenciador_alu;

  typedef struct packed {
    logic [3:0] data;
    logic       id;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;

  int n_cmp;
  int n_fail;

  // One element per instance: [0] ALU_LAT=2, [1] ALU_LAT=1, [2] ALU_LAT=15.
  logic       r0v[3], r0r[3], r1v[3], r1r[3];
  logic [7:0] r0i[3], r1i[3], ai[3];
  logic [3:0] r0a[3], r0b[3], r1a[3], r1b[3], aa[3], ab[3], ares[3], rdat[3];
  logic       rv[3], rr[3], rid[3], rerr[3], bsy[3];

  function automatic logic [3:0] alu_f(logic [7:0] ins, logic [3:0] a, logic [3:0] b);
    case (ins[7:5])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd7:    return b;
      default: return 4'hA;  // opcode 6: the scheduler must ignore this value
    endcase
  endfunction

  function automatic exp_t mk(logic id, logic [7:0] ins, logic [3:0] a, logic [3:0] b);
    exp_t e;
    e.id   = id;
    e.err  = (ins[7:5] == 3'h6);
    e.data = e.err ? 4'h0 : alu_f(ins, a, b);
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    int   age;
    exp_t q[$];
    exp_t e;

    secuenciador_alu #(.ALU_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (r0v[g]),
      .req0_ready (r0r[g]),
      .req0_instr (r0i[g]),
      .req0_a     (r0a[g]),
      .req0_b     (r0b[g]),
      .req1_valid (r1v[g]),
      .req1_ready (r1r[g]),
      .req1_instr (r1i[g]),
      .req1_a     (r1a[g]),
      .req1_b     (r1b[g]),
      .alu_instr  (ai[g]),
      .alu_a      (aa[g]),
      .alu_b      (ab[g]),
      .alu_result (ares[g]),
      .rsp_valid  (rv[g]),
      .rsp_ready  (rr[g]),
      .rsp_data   (rdat[g]),
      .rsp_id     (rid[g]),
      .rsp_err    (rerr[g]),
      .busy       (bsy[g])
    );

    // Behavioural ALU: the result is valid only once the operands have been
    // presented for LAT cycles. Before that it returns the inverted value.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) age <= 0;
      else if ((r0v[g] && r0r[g]) || (r1v[g] && r1r[g])) age <= 1;
      else if (age < 100) age <= age + 1;
    end
    assign ares[g] = (age >= LAT) ? alu_f(ai[g], aa[g], ab[g]) : ~alu_f(ai[g], aa[g], ab[g]);

    // Scoreboard
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (r0v[g] && r0r[g]) q.push_back(mk(1'b0, r0i[g], r0a[g], r0b[g]));
        if (r1v[g] && r1r[g]) q.push_back(mk(1'b1, r1i[g], r1a[g], r1b[g]));
        if (rv[g] && rr[g]) begin
          check("sb_rsp_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("sb_rsp_data", 32'(rdat[g]), 32'(e.data));
            check("sb_rsp_id", 32'(rid[g]), 32'(e.id));
            check("sb_rsp_err", 32'(rerr[g]), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic drive(int d, int n, logic v, logic [7:0] ins, logic [3:0] a, logic [3:0] b);
    if (n == 0) begin
      r0v[d] = v; r0i[d] = ins; r0a[d] = a; r0b[d] = b;
    end else begin
      r1v[d] = v; r1i[d] = ins; r1a[d] = a; r1b[d] = b;
    end
  endtask

  // Returns at the falling edge of the cycle in which a ready is high
  // (who = 0/1), or with who = -1 once the cycle budget is spent.
  task automatic wait_any_ready(int d, output int who);
    bit got;
    got = 1'b0;
    who = -1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (r0r[d] || r1r[d]) begin
        got = 1'b1;
        who = r1r[d] ? 1 : 0;
      end else begin
        @(posedge clk);
      end
    end
  endtask

  // Waits (bounded) for rsp_valid, then moves 1 time unit past the edge on
  // which the response is taken.
  task automatic wait_rsp_done(int d, string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (rv[d]) got = 1'b1;
      else @(posedge clk);
    end
    check(tag, 32'(rv[d]), 32'd1);
    @(posedge clk); #1;
  endtask

  // Single transaction. exp_lat is the cycle distance from the handshake
  // cycle to the first cycle with rsp_valid high.
  task automatic xact(int d, int n, logic [7:0] ins, logic [3:0] a, logic [3:0] b,
                      int exp_lat, string tag);
    int who;
    int k;
    bit got;
    drive(d, n, 1'b1, ins, a, b);
    wait_any_ready(d, who);
    check({tag, "_grant"}, 32'(who), 32'(n));
    @(posedge clk); #1;
    drive(d, n, 1'b0, ins, a, b);
    got = 1'b0;
    k = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (rv[d]) begin
        got = 1'b1;
        k = c;
      end else begin
        @(posedge clk);
      end
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int who;
    int t_prev;
    logic [2:0] ops [7];
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    t_prev = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 0, 1'b0, 8'h00, 4'h0, 4'h0);
      drive(d, 1, 1'b0, 8'h00, 4'h0, 4'h0);
      rr[d] = 1'b1;
    end

    // Reset state
    #12;
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_rsp_valid", 32'(rv[0]), 32'd0);
    check("rst_alu_instr", 32'(ai[0]), 32'd0);
    check("rst_alu_a", 32'(aa[0]), 32'd0);
    check("rst_alu_b", 32'(ab[0]), 32'd0);
    check("rst_rsp_data", 32'(rdat[0]), 32'd0);
    check("rst_rsp_id", 32'(rid[0]), 32'd0);
    check("rst_rsp_err", 32'(rerr[0]), 32'd0);
    check("rst_req0_ready", 32'(r0r[0]), 32'd0);
    check("rst_req1_ready", 32'(r1r[0]), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters valid from reset. Grants alternate, starting with
    // req0, and the next grant comes the cycle after each response handshake.
    drive(0, 0, 1'b1, 8'h00, 4'h5, 4'h6);
    drive(0, 1, 1'b1, 8'h20, 4'h9, 4'h2);
    for (int i = 0; i < 4; i++) begin
      wait_any_ready(0, who);
      check("t2_grant", 32'(who), 32'(i % 2));
      if (i > 0) check("t2_gap", 32'(cyc - t_prev), 32'd4);
      t_prev = cyc;
      @(posedge clk); #1;
      if (i == 3) begin
        r0v[0] = 1'b0;
        r1v[0] = 1'b0;
      end
      wait_rsp_done(0, "t2_rsp");
    end

    // Single req0 add: 3 + 4 = 7, response three cycles after the handshake.
    xact(0, 0, 8'h00, 4'h3, 4'h4, 3, "t1");

    // Each supported opcode with random operands, alternating requesters.
    for (int i = 0; i < 7; i++) begin
      xact(0, i % 2, {ops[i], 5'b0}, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 3, "op_sweep");
    end

    // Unsupported opcode from req1: error response one cycle after accept.
    xact(0, 1, 8'hC0, 4'h9, 4'h9, 1, "t3");

    // Backpressure: the response is held while rsp_ready is low, and req1 is
    // not accepted until the cycle after the response handshake.
    rr[0] = 1'b0;
    drive(0, 0, 1'b1, 8'h60, 4'h5, 4'hA);
    wait_any_ready(0, who);
    check("t4_grant", 32'(who), 32'd0);
    @(posedge clk); #1;
    r0v[0] = 1'b0;
    drive(0, 1, 1'b1, 8'h40, 4'hF, 4'h3);
    for (int c = 0; c < 10 && !rv[0]; c++) begin
      @(negedge clk);
      if (!rv[0]) @(posedge clk);
    end
    check("t4_rsp_valid", 32'(rv[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_hold_valid", 32'(rv[0]), 32'd1);
      check("t4_hold_data", 32'(rdat[0]), 32'hF);
      check("t4_hold_id", 32'(rid[0]), 32'd0);
      check("t4_hold_req1_ready", 32'(r1r[0]), 32'd0);
    end
    @(posedge clk); #1;
    rr[0] = 1'b1;
    @(negedge clk);
    check("t4_ready_in_hs_cycle", 32'(r1r[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_resume", 32'(r1r[0]), 32'd1);
    @(posedge clk); #1;
    r1v[0] = 1'b0;
    wait_rsp_done(0, "t4_rsp2");

    // Reset during WAIT: outputs clear at once, no response is produced, and
    // req0 wins the next arbitration even though it was granted last.
    drive(0, 0, 1'b1, 8'h00, 4'h1, 4'h1);
    wait_any_ready(0, who);
    check("t5_pre_grant", 32'(who), 32'd0);
    @(posedge clk); #1;
    r0v[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(bsy[0]), 32'd0);
    check("t5_rsp_valid", 32'(rv[0]), 32'd0);
    check("t5_alu_instr", 32'(ai[0]), 32'd0);
    check("t5_alu_a", 32'(aa[0]), 32'd0);
    check("t5_rsp_data", 32'(rdat[0]), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 8'h80, 4'h6, 4'h3);
    drive(0, 1, 1'b1, 8'hA0, 4'h2, 4'h0);
    wait_any_ready(0, who);
    check("t5_req0_first", 32'(who), 32'd0);
    @(posedge clk); #1;
    r0v[0] = 1'b0;
    wait_any_ready(0, who);
    check("t5_req1_second", 32'(who), 32'd1);
    @(posedge clk); #1;
    r1v[0] = 1'b0;
    wait_rsp_done(0, "t5_rsp");

    // Latency at the ends of the legal ALU_LAT range.
    xact(1, 0, 8'h00, 4'h7, 4'h8, 2, "t6_lat1_a");
    xact(1, 1, 8'h20, 4'h2, 4'h5, 2, "t6_lat1_b");
    xact(2, 0, 8'h00, 4'h9, 4'h9, 16, "t6_lat15_a");
    xact(2, 1, 8'hE0, 4'h3, 4'h4, 16, "t6_lat15_b");
    xact(2, 0, 8'hC0, 4'h1, 4'h2, 1, "t6_lat15_err");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
